gray_updown_counter: RTL and testbench

//   Parametrised up/down modulo counter with synchronous load and a registered Gray-code output.

---
 rtl/gray_updown_counter.sv | 124 ++++++++++++
 tb/tb_gray_updown_counter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/gray_updown_counter.sv
// gray_updown_counter
//   Up/down modulo counter with synchronous load. It has a registered binary
//   count and a registered Gray-code copy of that count. The counter either
//   wraps at the range boundaries or holds there, and it pulses a flag for
//   one cycle after each wrap.
//
// Parameters
//   WIDTH     counter width in bits (>= 2)
//   MODULUS   count range 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH
//   SATURATE  0: wrap at the boundaries, 1: hold at the boundaries
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   en        count enable, one step per clock while high
//   up        direction, 1 = increment, 0 = decrement
//   load      synchronous load request (wins over en)
//   load_val  value to load, clamped to MODULUS-1
//   bin       registered binary count
//   gray      registered Gray code of bin
//   wrap      one-cycle pulse, the current bin value came from a wrap
//   at_max    combinational, bin == MODULUS-1
//   at_min    combinational, bin == 0
module gray_updown_counter #(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned MODULUS  = 2**WIDTH,
   parameter bit          SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray,
   output logic             wrap,
   output logic             at_max,
   output logic             at_min
);

   // The top of the count range, in extended and native widths.
   localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MODULUS - 1);
   localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0]   ONE_EXT = (WIDTH+1)'(1);
   localparam logic [WIDTH:0]   ZERO_EXT = {(WIDTH+1){1'b0}};

   // A configuration that is out of range is rejected at elaboration.
   if ((MODULUS > 2**WIDTH) || (MODULUS < 2) || (WIDTH < 2)) begin : g_cfg_err
      initial $error("gray_updown_counter: illegal WIDTH/MODULUS configuration");
   end

   logic [WIDTH-1:0] bin_q,  bin_d;
   logic [WIDTH-1:0] gray_q, gray_d;
   logic             wrap_q, wrap_d;
   logic [WIDTH:0]   bin_ext_s;
   logic [WIDTH:0]   next_ext_s;
   logic [WIDTH:0]   load_ext_s;

   assign bin_ext_s  = {1'b0, bin_q};
   assign load_ext_s = {1'b0, load_val};

   // Next-state selection: reset > load > en > hold.
   always_comb begin
      next_ext_s = bin_ext_s;
      wrap_d     = 1'b0;
      if (reset) begin
         next_ext_s = ZERO_EXT;
      end else if (load) begin
         if (load_ext_s > MAX_EXT) begin
            next_ext_s = MAX_EXT;
         end else begin
            next_ext_s = load_ext_s;
         end
      end else if (en) begin
         if (up) begin
            if (bin_ext_s >= MAX_EXT) begin
               if (SATURATE) begin
                  next_ext_s = MAX_EXT;
               end else begin
                  next_ext_s = ZERO_EXT;
                  wrap_d     = 1'b1;
               end
            end else begin
               next_ext_s = bin_ext_s + ONE_EXT;
            end
         end else begin
            if (bin_ext_s == ZERO_EXT) begin
               if (SATURATE) begin
                  next_ext_s = ZERO_EXT;
               end else begin
                  next_ext_s = MAX_EXT;
                  wrap_d     = 1'b1;
               end
            end else begin
               next_ext_s = bin_ext_s - ONE_EXT;
            end
         end
      end else begin
         next_ext_s = bin_ext_s;
      end
   end

   // Narrow to WIDTH bits. The extra bit can never be set because every path
   // above is bounded by MAX_EXT. Masking with it keeps that bit observable.
   always_comb begin
      bin_d  = next_ext_s[WIDTH-1:0] & {WIDTH{~next_ext_s[WIDTH]}};
      gray_d = bin_d ^ (bin_d >> 1);
   end

   // bin, gray and wrap are registered together, so they have zero skew.
   always_ff @(posedge clk) begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
   end

   assign bin    = bin_q;
   assign gray   = gray_q;
   assign wrap   = wrap_q;
   assign at_max = (bin_q == MAX_W);
   assign at_min = (bin_q == {WIDTH{1'b0}});

endmodule

// File: tb/tb_gray_updown_counter.sv
module tb_gray_updown_counter;

   logic       clk = 1'b0;
   logic       reset, en, up, load;
   logic [3:0] load_val;
   logic [3:0] bin_w, gray_w, bin_s, gray_s;
   logic       wrap_w, max_w, min_w, wrap_s, max_s, min_s;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   gray_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) dut_wrap (
      .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
      .bin(bin_w), .gray(gray_w), .wrap(wrap_w), .at_max(max_w), .at_min(min_w)
   );

   gray_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) dut_sat (
      .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
      .bin(bin_s), .gray(gray_s), .wrap(wrap_s), .at_max(max_s), .at_min(min_s)
   );

   typedef struct {
      logic       reset, en, up, load;
      logic [3:0] load_val;
      logic [3:0] e_bin, e_gray;
      logic       e_wrap, e_max, e_min;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic r, input logic e, input logic u, input logic l,
                      input logic [3:0] lv, input logic [3:0] b, input logic [3:0] g,
                      input logic w);
      vec_t v;
      v.reset = r; v.en = e; v.up = u; v.load = l; v.load_val = lv;
      v.e_bin = b; v.e_gray = g; v.e_wrap = w;
      v.e_max = (b == 4'd9);
      v.e_min = (b == 4'd0);
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [3:0] act,
                      input logic [3:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic e, input logic u, input logic l,
                       input logic [3:0] lv);
      reset = r; en = e; up = u; load = l; load_val = lv;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 4'd0;

      // Reset state.
      add(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'h0, 1'b0);
      // Count up through the wrap.
      add(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd1, 4'h1, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd2, 4'h3, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd3, 4'h2, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd4, 4'h6, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd5, 4'h7, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd6, 4'h5, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd7, 4'h4, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd8, 4'hC, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd9, 4'hD, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'h0, 1'b1);
      add(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd1, 4'h1, 1'b0);
      // Hold with en low. The wrap pulse stays clear.
      add(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd1, 4'h1, 1'b0);
      // Count down from reset through the wrap.
      add(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'h0, 1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd9, 4'hD, 1'b1);
      add(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd8, 4'hC, 1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd7, 4'h4, 1'b0);
      // Load beats en, and an out-of-range value clamps.
      add(1'b0, 1'b1, 1'b1, 1'b1, 4'd12, 4'd9, 4'hD, 1'b0);
      // An in-range load at the boundary does not wrap.
      add(1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 4'h0, 1'b0);
      // Count to 5, then reset beats en and load.
      add(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd1, 4'h1, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd2, 4'h3, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd3, 4'h2, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd4, 4'h6, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd5, 4'h7, 1'b0);
      add(1'b1, 1'b1, 1'b1, 1'b1, 4'd7, 4'd0, 4'h0, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd1, 4'h1, 1'b0);
      // Reach 3, then toggle the direction every cycle.
      add(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd2, 4'h3, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd3, 4'h2, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd4, 4'h6, 1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd3, 4'h2, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd4, 4'h6, 1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd3, 4'h2, 1'b0);

      for (int i = 0; i < vq.size(); i++) begin
         step(vq[i].reset, vq[i].en, vq[i].up, vq[i].load, vq[i].load_val);
         chk("bin",    i, bin_w,  vq[i].e_bin);
         chk("gray",   i, gray_w, vq[i].e_gray);
         chk("wrap",   i, {3'b000, wrap_w}, {3'b000, vq[i].e_wrap});
         chk("at_max", i, {3'b000, max_w},  {3'b000, vq[i].e_max});
         chk("at_min", i, {3'b000, min_w},  {3'b000, vq[i].e_min});
      end

      // Saturating instance: hold at the top, then step down.
      step(1'b0, 1'b0, 1'b1, 1'b1, 4'd8);
      chk("sat_load", 0, bin_s, 4'd8);
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
         chk("sat_up_bin",  k, bin_s, 4'd9);
         chk("sat_up_gray", k, gray_s, 4'hD);
         chk("sat_up_wrap", k, {3'b000, wrap_s}, 4'd0);
         chk("sat_at_max",  k, {3'b000, max_s}, 4'd1);
      end
      step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      chk("sat_down_bin", 0, bin_s, 4'd8);
      chk("sat_down_gray", 0, gray_s, 4'hC);

      // Saturating instance: hold at the bottom.
      step(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
      for (int k = 0; k < 2; k++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
         chk("sat_min_bin",  k, bin_s, 4'd0);
         chk("sat_min_wrap", k, {3'b000, wrap_s}, 4'd0);
         chk("sat_at_min",   k, {3'b000, min_s}, 4'd1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
